// File: rtl/dcache_nway_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_nway_if
//  Description : Datapath and memory bus bundle for the n-way data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_nway_if;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic        halt;
   logic        dhit;
   logic [31:0] dmemload;
   logic        flushed;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;

   // master: datapath plus memory environment; slave: the cache itself
   modport master (
      output dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
      input  dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );
   modport slave (
      input  dmemREN, dmemWEN, dmemaddr, dmemstore, halt, dload, dwait,
      output dhit, dmemload, flushed, dREN, dWEN, daddr, dstore
   );
endinterface
`default_nettype wire

// File: rtl/dcache_nway.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_nway
//  Description : Set-associative write-back data cache with LRU replacement
//                and a halt-triggered flush of all dirty blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_nway #(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2
) (
   input  logic          CLK,
   input  logic          RST,
   dcache_nway_if.slave  dcif
);
   localparam int c_OFF_W = $clog2(WORDS);
   localparam int c_IDX_W = $clog2(SETS);
   localparam int c_TAG_W = 30 - c_OFF_W - c_IDX_W;
   localparam int c_CNT_W = (c_OFF_W > 0) ? c_OFF_W : 1;
   localparam int c_WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WB    = 3'd1,
      FILL  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t r_state, w_state_n;

   logic               r_valid [SETS][WAYS];
   logic               r_dirty [SETS][WAYS];
   logic [c_TAG_W-1:0] r_tag   [SETS][WAYS];
   logic [c_WAY_W-1:0] r_age   [SETS][WAYS];
   logic [31:0]        r_data  [SETS][WAYS][WORDS];

   logic [c_CNT_W-1:0] r_cnt;
   logic [c_WAY_W-1:0] r_vic;
   logic [c_IDX_W-1:0] r_fset;
   logic [c_WAY_W-1:0] r_fway;

   logic [29:0]        w_word;
   logic [c_CNT_W-1:0] w_off;
   logic [c_IDX_W-1:0] w_idx;
   logic [c_TAG_W-1:0] w_tag;
   logic               w_req, w_hit, w_inv, w_last, w_fdirty, w_flast, w_fadv;
   logic [c_WAY_W-1:0] w_hway, w_vic;
   logic               w_dhit, w_ren, w_wen, w_flushed;
   logic [31:0]        w_load, w_addr, w_store;

   function automatic logic [31:0] f_addr(input logic [c_TAG_W-1:0] t,
                                          input logic [c_IDX_W-1:0] s,
                                          input logic [c_CNT_W-1:0] c);
      logic [31:0] wd;
      wd = (32'(t) << (c_OFF_W + c_IDX_W)) | (32'(s) << c_OFF_W) | 32'(c);
      return wd << 2;
   endfunction

   assign w_word   = dcif.dmemaddr[31:2];
   assign w_off    = c_CNT_W'(w_word & 30'(WORDS - 1));
   assign w_idx    = c_IDX_W'(w_word >> c_OFF_W);
   assign w_tag    = c_TAG_W'(w_word >> (c_OFF_W + c_IDX_W));
   assign w_req    = dcif.dmemREN | dcif.dmemWEN;
   assign w_last   = (r_cnt == c_CNT_W'(WORDS - 1));
   assign w_fdirty = r_valid[r_fset][r_fway] & r_dirty[r_fset][r_fway];
   assign w_flast  = (r_fset == c_IDX_W'(SETS - 1)) && (r_fway == c_WAY_W'(WAYS - 1));

   // Tag lookup and victim choice: first invalid way, else the oldest way
   always_comb begin
      w_hit  = 1'b0;
      w_hway = '0;
      w_inv  = 1'b0;
      w_vic  = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!w_hit && r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
            w_hit  = 1'b1;
            w_hway = c_WAY_W'(w);
         end
         if (!w_inv && !r_valid[w_idx][w]) begin
            w_inv = 1'b1;
            w_vic = c_WAY_W'(w);
         end
      end
      if (!w_inv) begin
         for (int w = 0; w < WAYS; w++) begin
            if (r_age[w_idx][w] == c_WAY_W'(WAYS - 1)) w_vic = c_WAY_W'(w);
         end
      end
   end

   always_comb begin
      w_state_n = r_state;
      w_dhit    = 1'b0;
      w_load    = '0;
      w_ren     = 1'b0;
      w_wen     = 1'b0;
      w_addr    = '0;
      w_store   = '0;
      w_flushed = 1'b0;
      w_fadv    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (dcif.halt) begin
               w_state_n = FLUSH;
            end else if (w_req) begin
               if (w_hit) begin
                  w_dhit = 1'b1;
                  w_load = r_data[w_idx][w_hway][w_off];
               end else begin
                  w_state_n = r_dirty[w_idx][w_vic] ? WB : FILL;
               end
            end
         end
         WB: begin
            w_wen   = 1'b1;
            w_addr  = f_addr(r_tag[w_idx][r_vic], w_idx, r_cnt);
            w_store = r_data[w_idx][r_vic][r_cnt];
            if (!dcif.dwait && w_last) w_state_n = FILL;
         end
         FILL: begin
            w_ren  = 1'b1;
            w_addr = f_addr(w_tag, w_idx, r_cnt);
            if (!dcif.dwait && w_last) w_state_n = IDLE;
         end
         FLUSH: begin
            if (w_fdirty) begin
               w_wen   = 1'b1;
               w_addr  = f_addr(r_tag[r_fset][r_fway], r_fset, r_cnt);
               w_store = r_data[r_fset][r_fway][r_cnt];
               w_fadv  = !dcif.dwait && w_last;
            end else begin
               w_fadv = 1'b1;
            end
            if (w_fadv && w_flast) w_state_n = DONE;
         end
         DONE:    w_flushed = 1'b1;
         default: w_state_n = IDLE;
      endcase
   end

   // Reset forces every output low in the same cycle it is asserted
   assign dcif.dhit     = w_dhit & ~RST;
   assign dcif.dmemload = RST ? '0 : w_load;
   assign dcif.flushed  = w_flushed & ~RST;
   assign dcif.dREN     = w_ren & ~RST;
   assign dcif.dWEN     = w_wen & ~RST;
   assign dcif.daddr    = RST ? '0 : w_addr;
   assign dcif.dstore   = RST ? '0 : w_store;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_vic   <= '0;
         r_fset  <= '0;
         r_fway  <= '0;
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               r_valid[s][w] <= 1'b0;
               r_dirty[s][w] <= 1'b0;
               r_age[s][w]   <= c_WAY_W'(w);
            end
         end
      end else begin
         r_state <= w_state_n;
         unique case (r_state)
            IDLE: begin
               if (dcif.halt) begin
                  r_fset <= '0;
                  r_fway <= '0;
                  r_cnt  <= '0;
               end else if (w_req && w_hit) begin
                  for (int w = 0; w < WAYS; w++) begin
                     if (c_WAY_W'(w) == w_hway)
                        r_age[w_idx][w] <= '0;
                     else if (r_age[w_idx][w] < r_age[w_idx][w_hway])
                        r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                  end
                  if (dcif.dmemWEN) begin
                     r_data[w_idx][w_hway][w_off] <= dcif.dmemstore;
                     r_dirty[w_idx][w_hway]       <= 1'b1;
                  end
               end else if (w_req) begin
                  r_vic <= w_vic;
               end
            end
            WB: begin
               if (!dcif.dwait) begin
                  if (w_last) begin
                     r_cnt                <= '0;
                     r_dirty[w_idx][r_vic] <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            FILL: begin
               if (!dcif.dwait) begin
                  r_data[w_idx][r_vic][r_cnt] <= dcif.dload;
                  if (w_last) begin
                     r_cnt                 <= '0;
                     r_valid[w_idx][r_vic] <= 1'b1;
                     r_tag[w_idx][r_vic]   <= w_tag;
                     r_dirty[w_idx][r_vic] <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            FLUSH: begin
               if (w_fdirty && !dcif.dwait) begin
                  if (w_last) begin
                     r_cnt                  <= '0;
                     r_dirty[r_fset][r_fway] <= 1'b0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               if (w_fadv) begin
                  if (r_fway == c_WAY_W'(WAYS - 1)) begin
                     r_fway <= '0;
                     r_fset <= r_fset + 1'b1;
                  end else begin
                     r_fway <= r_fway + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
`default_nettype wire
